// File: rtl/serial_adder.sv
// Bit-serial adder controller: streams LSB-first bit pairs through an external
// combinational full adder, recirculating its carry and collecting its sum bits.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_so,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] sreg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg_next;

    // The final edge must publish the sum including the bit returned this cycle.
    assign sreg_next = {fa_so, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            areg  <= '0;
            breg  <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    sreg  <= sreg_next;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= sreg_next;
                        cout  <= fa_cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign fa_a   = busy & areg[0];
    assign fa_b   = busy & breg[0];
    assign fa_cin = busy & carry;

endmodule
